// File: rtl/ttt_pkg.sv
// Shared types and helpers for the sequential O-move generator (ttt_move_seq).
package ttt_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    WIN   = 2'd1,
    BLOCK = 2'd2,
    FILL  = 2'd3
  } move_kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int center_idx(input int n);
    return (n / 2) * n + n / 2;
  endfunction

endpackage

// File: rtl/ttt_cell_threat.sv
// Combinational threat test for one cell: does an empty cell complete a K-run
// for O (win_hit) or for X (block_hit) in any on-board window through it.
module ttt_cell_threat #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [N*N-1:0]         x_board,
  input  logic [N*N-1:0]         o_board,
  input  logic [$clog2(N*N)-1:0] cell_idx,
  output logic                   win_hit,
  output logic                   block_hit
);

  localparam int CELLS = N * N;
  localparam logic [CELLS-1:0] ONE = {{(CELLS-1){1'b0}}, 1'b1};

  logic [CELLS-1:0] win_mask;
  logic             on_board;
  logic             cell_empty;
  int               r, c, dr, dc, sr, sc, rr, cc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win_hit    = 1'b0;
    block_hit  = 1'b0;
    win_mask   = '0;
    on_board   = 1'b0;
    dr         = 0;
    dc         = 0;
    sr         = 0;
    sc         = 0;
    rr         = 0;
    cc         = 0;
    r          = int'(cell_idx) / N;
    c          = int'(cell_idx) % N;
    cell_empty = ((x_board | o_board) & (ONE << cell_idx)) == '0;

    // Directions: horizontal, vertical, diagonal, anti-diagonal; every window
    // start that places this cell at offset 'off' inside the run.
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dr = 0; dc = 1;  end
        1:       begin dr = 1; dc = 0;  end
        2:       begin dr = 1; dc = 1;  end
        default: begin dr = 1; dc = -1; end
      endcase
      for (int off = 0; off < K; off++) begin
        sr       = r - off * dr;
        sc       = c - off * dc;
        on_board = 1'b1;
        win_mask = '0;
        for (int j = 0; j < K; j++) begin
          rr = sr + j * dr;
          cc = sc + j * dc;
          if (rr < 0 || rr >= N || cc < 0 || cc >= N) on_board = 1'b0;
          else win_mask = win_mask | (ONE << (rr * N + cc));
        end
        if (on_board && cell_empty) begin
          if ($countones(o_board & win_mask) == K - 1 &&
              $countones(x_board & win_mask) == 0) win_hit = 1'b1;
          if ($countones(x_board & win_mask) == K - 1 &&
              $countones(o_board & win_mask) == 0) block_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ttt_move_seq.sv
// Sequential O-move generator: scans one cell per cycle, answers win > block > center > fill.
// Optional macro TTT_MOVE_SEQ_EARLY_EXIT_EN ends the scan at the first win.
module ttt_move_seq
  import ttt_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [N*N-1:0]         x_board,
  input  logic [N*N-1:0]         o_board,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [N*N-1:0]         new_o,
  output logic [$clog2(N*N)-1:0] move_idx,
  output move_kind_t             move_kind,
  output logic                   busy
);

  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0] CENTER_IDX = IDX_W'(center_idx(N));
  localparam bit               ODD_N      = (N % 2) == 1;
  localparam logic [CELLS-1:0] ONE        = {{(CELLS-1){1'b0}}, 1'b1};
`ifdef TTT_MOVE_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CELLS-1:0] x_q, x_d, o_q, o_d;
  logic [IDX_W-1:0] cell_q, cell_d;
  logic             win_vld_q, win_vld_d, blk_vld_q, blk_vld_d, emp_vld_q, emp_vld_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d, blk_idx_q, blk_idx_d, emp_idx_q, emp_idx_d;
  logic [CELLS-1:0] new_o_q, new_o_d;
  logic [IDX_W-1:0] move_idx_q, move_idx_d;
  move_kind_t       move_kind_q, move_kind_d;

  logic win_hit, block_hit, cell_empty, center_empty, scan_end;

  ttt_cell_threat #(.N(N), .K(K)) u_threat (
    .x_board   (x_q),
    .o_board   (o_q),
    .cell_idx  (cell_q),
    .win_hit   (win_hit),
    .block_hit (block_hit)
  );

  assign cell_empty   = !(x_q[cell_q] || o_q[cell_q]);
  assign center_empty = ODD_N && !(x_q[CENTER_IDX] || o_q[CENTER_IDX]);
  assign scan_end     = (cell_q == LAST_IDX) || (EARLY_EXIT && win_hit);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SCAN;
      SCAN:    if (scan_end)  state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    x_d         = x_q;
    o_d         = o_q;
    cell_d      = cell_q;
    win_vld_d   = win_vld_q;
    win_idx_d   = win_idx_q;
    blk_vld_d   = blk_vld_q;
    blk_idx_d   = blk_idx_q;
    emp_vld_d   = emp_vld_q;
    emp_idx_d   = emp_idx_q;
    new_o_d     = new_o_q;
    move_idx_d  = move_idx_q;
    move_kind_d = move_kind_q;

    if (state_q == IDLE && req_valid) begin
      x_d       = x_board;
      o_d       = o_board;
      cell_d    = '0;
      win_vld_d = 1'b0;
      blk_vld_d = 1'b0;
      emp_vld_d = 1'b0;
      win_idx_d = '0;
      blk_idx_d = '0;
      emp_idx_d = '0;
    end else if (state_q == SCAN) begin
      cell_d = cell_q + 1'b1;
      if (win_hit && !win_vld_q)    begin win_vld_d = 1'b1; win_idx_d = cell_q; end
      if (block_hit && !blk_vld_q)  begin blk_vld_d = 1'b1; blk_idx_d = cell_q; end
      if (cell_empty && !emp_vld_q) begin emp_vld_d = 1'b1; emp_idx_d = cell_q; end

      // Selection uses the _d candidates so the final cell's hits take part.
      if (scan_end) begin
        if (win_vld_d) begin
          move_kind_d = WIN;
          move_idx_d  = win_idx_d;
        end else if (blk_vld_d) begin
          move_kind_d = BLOCK;
          move_idx_d  = blk_idx_d;
        end else if (center_empty) begin
          move_kind_d = FILL;
          move_idx_d  = CENTER_IDX;
        end else if (emp_vld_d) begin
          move_kind_d = FILL;
          move_idx_d  = emp_idx_d;
        end else begin
          move_kind_d = NONE;
          move_idx_d  = '0;
        end
        new_o_d = (move_kind_d == NONE) ? o_q : (o_q | (ONE << move_idx_d));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= '0;
      o_q         <= '0;
      cell_q      <= '0;
      win_vld_q   <= 1'b0;
      win_idx_q   <= '0;
      blk_vld_q   <= 1'b0;
      blk_idx_q   <= '0;
      emp_vld_q   <= 1'b0;
      emp_idx_q   <= '0;
      new_o_q     <= '0;
      move_idx_q  <= '0;
      move_kind_q <= NONE;
    end else begin
      x_q         <= x_d;
      o_q         <= o_d;
      cell_q      <= cell_d;
      win_vld_q   <= win_vld_d;
      win_idx_q   <= win_idx_d;
      blk_vld_q   <= blk_vld_d;
      blk_idx_q   <= blk_idx_d;
      emp_vld_q   <= emp_vld_d;
      emp_idx_q   <= emp_idx_d;
      new_o_q     <= new_o_d;
      move_idx_q  <= move_idx_d;
      move_kind_q <= move_kind_d;
    end
  end

  assign new_o     = new_o_q;
  assign move_idx  = move_idx_q;
  assign move_kind = move_kind_q;

endmodule

// File: tb/tb_ttt_move_seq.sv
// Directed scoreboard bench for ttt_move_seq: N=3/K=3 and N=4/K=3 instances.
module tb_ttt_move_seq;
  import ttt_pkg::*;

  typedef struct {
    logic [31:0] new_o;
    logic [31:0] idx;
    logic [31:0] kind;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req_valid, rsp_ready, sel4;

  logic [8:0]  x3, o3, new_o3;
  logic [3:0]  idx3;
  move_kind_t  kind3;
  logic        rdy3, vld3, busy3;

  logic [15:0] x4, o4, new_o4;
  logic [3:0]  idx4;
  move_kind_t  kind4;
  logic        rdy4, vld4, busy4;

  logic [31:0] obs_new_o, obs_idx, obs_kind;
  logic        obs_req_ready, obs_rsp_valid, obs_busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  ttt_move_seq #(.N(3), .K(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid && !sel4),
    .req_ready (rdy3),
    .x_board   (x3),
    .o_board   (o3),
    .rsp_valid (vld3),
    .rsp_ready (rsp_ready && !sel4),
    .new_o     (new_o3),
    .move_idx  (idx3),
    .move_kind (kind3),
    .busy      (busy3)
  );

  ttt_move_seq #(.N(4), .K(3)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid && sel4),
    .req_ready (rdy4),
    .x_board   (x4),
    .o_board   (o4),
    .rsp_valid (vld4),
    .rsp_ready (rsp_ready && sel4),
    .new_o     (new_o4),
    .move_idx  (idx4),
    .move_kind (kind4),
    .busy      (busy4)
  );

  assign obs_new_o     = sel4 ? 32'(new_o4) : 32'(new_o3);
  assign obs_idx       = sel4 ? 32'(idx4)   : 32'(idx3);
  assign obs_kind      = sel4 ? 32'(kind4)  : 32'(kind3);
  assign obs_req_ready = sel4 ? rdy4  : rdy3;
  assign obs_rsp_valid = sel4 ? vld4  : vld3;
  assign obs_busy      = sel4 ? busy4 : busy3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected response latency in cycles after the request handshake edge.
  function automatic int exp_lat(input logic [31:0] kind, input logic [31:0] idx, input int cells);
`ifdef TTT_MOVE_SEQ_EARLY_EXIT_EN
    if (kind == 32'(WIN)) return int'(idx) + 2;
`endif
    return cells + 1;
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] o, input logic [31:0] e_new_o,
                      input logic [31:0] e_idx, input move_kind_t e_kind, input int hold);
    exp_t e;
    int   lat;
    logic [31:0] held_o, held_idx, held_kind;
    e.new_o = e_new_o;
    e.idx   = e_idx;
    e.kind  = 32'(e_kind);
    e.lat   = exp_lat(32'(e_kind), e_idx, sel4 ? 16 : 9);
    sb_q.push_back(e);

    @(negedge clk);
    if (sel4) begin x4 = x[15:0]; o4 = o[15:0]; end
    else      begin x3 = x[8:0];  o3 = o[8:0];  end
    req_valid = 1'b1;
    check("req_ready_idle", 32'(obs_req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!obs_rsp_valid && lat < 60);

    e = sb_q.pop_front();
    check("rsp_valid", 32'(obs_rsp_valid), 32'd1);
    check("latency", 32'(lat), 32'(e.lat));
    check("new_o", obs_new_o, e.new_o);
    check("move_idx", obs_idx, e.idx);
    check("move_kind", obs_kind, e.kind);
    check("busy_done", 32'(obs_busy), 32'd1);
    check("req_ready_done", 32'(obs_req_ready), 32'd0);

    held_o    = obs_new_o;
    held_idx  = obs_idx;
    held_kind = obs_kind;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(obs_rsp_valid), 32'd1);
      check("hold_req_ready", 32'(obs_req_ready), 32'd0);
      check("hold_new_o", obs_new_o, held_o);
      check("hold_idx", obs_idx, held_idx);
      check("hold_kind", obs_kind, held_kind);
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    check("idle_req_ready", 32'(obs_req_ready), 32'd1);
    check("idle_busy", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    int seen_rsp;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    sel4      = 1'b0;
    x3 = '0; o3 = '0; x4 = '0; o4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("rst_req_ready", 32'(rdy3), 32'd1);
    check("rst_rsp_valid", 32'(vld3), 32'd0);
    check("rst_new_o", 32'(new_o3), 32'd0);
    check("rst_move_idx", 32'(idx3), 32'd0);
    check("rst_move_kind", 32'(kind3), 32'(NONE));
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst4_req_ready", 32'(rdy4), 32'd1);
    check("rst4_busy", 32'(busy4), 32'd0);
    rst_n = 1'b1;

    // N=3 directed cases
    send(32'h030, 32'h003, 32'h007, 32'd2, WIN,   0);
    send(32'h003, 32'h010, 32'h014, 32'd2, BLOCK, 5);
    send(32'h003, 32'h0C0, 32'h1C0, 32'd8, WIN,   0);
    send(32'h001, 32'h000, 32'h010, 32'd4, FILL,  0);
    send(32'h155, 32'h0AA, 32'h0AA, 32'd0, NONE,  0);
    send(32'h010, 32'h000, 32'h001, 32'd0, FILL,  0);
    // O at cells 2 and 3 must not form a row wrapping across the board edge
    send(32'h000, 32'h00C, 32'h01C, 32'd4, FILL,  0);

    // Reset in the middle of a scan aborts without a response
    @(negedge clk);
    x3 = 9'h030; o3 = 9'h003;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scan_busy", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_rsp_valid", 32'(vld3), 32'd0);
    check("abort_req_ready", 32'(rdy3), 32'd1);
    check("abort_busy", 32'(busy3), 32'd0);
    check("abort_kind", 32'(kind3), 32'(NONE));
    rst_n = 1'b1;
    seen_rsp = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (vld3) seen_rsp++;
    end
    check("abort_no_rsp", 32'(seen_rsp), 32'd0);

    // N=4, K=3
    sel4 = 1'b1;
    send(32'h0000, 32'h0003, 32'h0007, 32'd2, WIN, 0);
    sel4 = 1'b0;

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
